// File: rtl/rv_imem_pipe_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rv_imem_pipe_if
// Fetch-side bus between the IF stage and the instruction memory.
//   master (IF stage)   drives   req_valid, req_addr, flush
//                       receives req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
//   slave  (IMEM)       is the mirror image of master
// ---------------------------------------------------------------------------
interface rv_imem_pipe_if;
   logic        req_valid;  // fetch request
   logic [31:0] req_addr;   // byte address
   logic        req_ready;  // request accepted when req_valid & req_ready
   logic        flush;      // kill all in-flight responses
   logic        rsp_valid;  // response valid
   logic [31:0] rsp_data;   // instruction word
   logic [31:0] rsp_addr;   // byte address of the response
   logic        rsp_err;    // misaligned or out-of-range request

   modport master (
      output req_valid, req_addr, flush,
      input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, flush,
      output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
   );
endinterface

// File: rtl/rv_imem_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rv_imem_pipe
// Pipelined instruction memory for the rv_cpu fetch path.
//   - LATENCY-deep read pipeline, one request per cycle, no backpressure
//   - synchronous loader write port (honoured only once the fill is done)
//   - post-reset NOP fill of the whole array
//   - flush kills in-flight responses; a request accepted with the flush
//     survives (it is the redirected fetch)
// Ports:
//   clk, rst    core clock, asynchronous active-high reset
//   bus         fetch request/response bus (slave side)
//   ld_en       loader write strobe
//   ld_addr     loader word index
//   ld_data     loader write data
//   init_busy   NOP fill in progress
// ---------------------------------------------------------------------------
module rv_imem_pipe #(
   parameter int unsigned    DEPTH    = 64,
   parameter int unsigned    LATENCY  = 1,
   parameter logic [31:0]    NOP_WORD = 32'h0000_0013,
   localparam int unsigned   IDX_W    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   rv_imem_pipe_if.slave    bus,
   input  logic             ld_en,
   input  logic [IDX_W-1:0] ld_addr,
   input  logic [31:0]      ld_data,
   output logic             init_busy
);

   typedef enum logic {FILL, RUN} state_t;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] addr;
      logic [31:0] data;
   } stage_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] fill_cnt;
   logic [31:0]      mem [DEPTH];
   stage_t           stg [LATENCY];   // stg[0] is stage 1, stg[LATENCY-1] drives rsp_*

   logic             accept;
   logic             rd_err;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0]      rd_word;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      if (rst) begin
         state_q  <= FILL;
         fill_cnt <= '0;
      end else begin
         state_q <= state_d;
         // Wraps back to 0 on the last fill write; unused in RUN.
         if (state_q == FILL) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d       = state_q;
      init_busy     = 1'b1;
      bus.req_ready = 1'b0;
      unique case (state_q)
         FILL: if (fill_cnt == IDX_W'(DEPTH - 1)) state_d = RUN;
         RUN: begin
            init_busy     = 1'b0;
            bus.req_ready = 1'b1;
         end
      endcase
   end

   // ---------------- storage ----------------
   // NOTE: the array has no reset; the FILL state initialises it one word per
   // cycle, which keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (state_q == FILL)  mem[fill_cnt] <= NOP_WORD;
      else if (ld_en)       mem[ld_addr]  <= ld_data;
   end

   // Read happens before the edge, so a same-cycle loader write to the same
   // index is seen only by the next accepted request.
   assign accept  = bus.req_valid & bus.req_ready;
   assign rd_idx  = bus.req_addr[IDX_W+1:2];
   assign rd_err  = (|bus.req_addr[1:0]) | (|bus.req_addr[31:IDX_W+2]);
   assign rd_word = mem[rd_idx];

   // ---------------- read pipeline ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stg[i] <= '{valid: 1'b0, err: 1'b0, addr: '0, data: NOP_WORD};
         end
      end else begin
         // Stage 1 ignores flush: the request taken on the flush edge is the redirect.
         stg[0].valid <= accept;
         stg[0].err   <= rd_err;
         stg[0].addr  <= bus.req_addr;
         stg[0].data  <= rd_err ? NOP_WORD : rd_word;
         for (int i = 1; i < LATENCY; i++) begin
            stg[i].valid <= stg[i-1].valid & ~bus.flush;
            stg[i].err   <= stg[i-1].err;
            stg[i].addr  <= stg[i-1].addr;
            stg[i].data  <= stg[i-1].data;
         end
      end
   end

   // Payload is gated by valid so killed or idle stages never leak stale data.
   assign bus.rsp_valid = stg[LATENCY-1].valid;
   assign bus.rsp_err   = stg[LATENCY-1].valid & stg[LATENCY-1].err;
   assign bus.rsp_addr  = stg[LATENCY-1].valid ? stg[LATENCY-1].addr : '0;
   assign bus.rsp_data  = stg[LATENCY-1].valid ? stg[LATENCY-1].data : NOP_WORD;

endmodule

// File: tb/tb_rv_imem_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rv_imem_pipe
// Three instances (LATENCY 1, 3, 4; DEPTH 64) share one stimulus stream.
// A reference model keeps a word array and, per instance, a table of expected
// responses indexed by the clock edge at which each one must be visible.
// ---------------------------------------------------------------------------
module tb_rv_imem_pipe;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          NDUT  = 3;
   localparam int          SLOTS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr  = '0;
   logic        flush     = 1'b0;
   logic        ld_en     = 1'b0;
   logic [5:0]  ld_addr   = '0;
   logic [31:0] ld_data   = '0;

   rv_imem_pipe_if bus0 ();
   rv_imem_pipe_if bus1 ();
   rv_imem_pipe_if bus2 ();

   assign bus0.req_valid = req_valid;  assign bus0.req_addr = req_addr;  assign bus0.flush = flush;
   assign bus1.req_valid = req_valid;  assign bus1.req_addr = req_addr;  assign bus1.flush = flush;
   assign bus2.req_valid = req_valid;  assign bus2.req_addr = req_addr;  assign bus2.flush = flush;

   logic busy0, busy1, busy2;

   rv_imem_pipe #(.DEPTH(DEPTH), .LATENCY(1), .NOP_WORD(NOP)) u_l1 (
      .clk(clk), .rst(rst), .bus(bus0), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .init_busy(busy0));
   rv_imem_pipe #(.DEPTH(DEPTH), .LATENCY(3), .NOP_WORD(NOP)) u_l3 (
      .clk(clk), .rst(rst), .bus(bus1), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .init_busy(busy1));
   rv_imem_pipe #(.DEPTH(DEPTH), .LATENCY(4), .NOP_WORD(NOP)) u_l4 (
      .clk(clk), .rst(rst), .bus(bus2), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .init_busy(busy2));

   always #5 clk = ~clk;

   // DUT outputs gathered for looping
   logic        o_valid [NDUT];
   logic [31:0] o_data  [NDUT];
   logic [31:0] o_addr  [NDUT];
   logic        o_err   [NDUT];
   logic        o_ready [NDUT];
   logic        o_busy  [NDUT];

   assign o_valid[0] = bus0.rsp_valid; assign o_data[0] = bus0.rsp_data; assign o_addr[0] = bus0.rsp_addr;
   assign o_err[0]   = bus0.rsp_err;   assign o_ready[0] = bus0.req_ready; assign o_busy[0] = busy0;
   assign o_valid[1] = bus1.rsp_valid; assign o_data[1] = bus1.rsp_data; assign o_addr[1] = bus1.rsp_addr;
   assign o_err[1]   = bus1.rsp_err;   assign o_ready[1] = bus1.req_ready; assign o_busy[1] = busy1;
   assign o_valid[2] = bus2.rsp_valid; assign o_data[2] = bus2.rsp_data; assign o_addr[2] = bus2.rsp_addr;
   assign o_err[2]   = bus2.rsp_err;   assign o_ready[2] = bus2.req_ready; assign o_busy[2] = busy2;

   // ---------------- reference model ----------------
   logic [31:0] mem_m [DEPTH];
   logic        exp_v [NDUT][SLOTS];
   logic [31:0] exp_d [NDUT][SLOTS];
   logic [31:0] exp_a [NDUT][SLOTS];
   logic        exp_e [NDUT][SLOTS];
   int          edges;          // clock edges since reset was released
   int          n_vec  = 0;
   int          n_fail = 0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 3 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %08h expected %08h", tag, $time, got, want);
      end
   endtask

   // Reset (and the fill that follows) leaves every word holding NOP and nothing in flight.
   task automatic model_reset();
      edges = 0;
      for (int w = 0; w < DEPTH; w++) mem_m[w] = NOP;
      for (int d = 0; d < NDUT; d++)
         for (int s = 0; s < SLOTS; s++) exp_v[d][s] = 1'b0;
   endtask

   task automatic check_outputs();
      int s;
      s = edges % SLOTS;
      for (int d = 0; d < NDUT; d++) begin
         string p;
         p = $sformatf("L%0d", lat_of(d));
         check({p, " rsp_valid"}, 32'(o_valid[d]), 32'(exp_v[d][s]));
         check({p, " rsp_data"},  o_data[d],  exp_v[d][s] ? exp_d[d][s] : NOP);
         check({p, " rsp_addr"},  o_addr[d],  exp_v[d][s] ? exp_a[d][s] : 32'h0);
         check({p, " rsp_err"},   32'(o_err[d]), exp_v[d][s] ? 32'(exp_e[d][s]) : 32'h0);
         check({p, " init_busy"}, 32'(o_busy[d]),  32'(edges < DEPTH));
         check({p, " req_ready"}, 32'(o_ready[d]), 32'(edges >= DEPTH));
         exp_v[d][s] = 1'b0;
      end
   endtask

   // Apply one cycle of stimulus, update the model for the coming edge, then
   // check the outputs half a cycle after that edge.
   task automatic step(input logic v, input logic [31:0] a, input logic fl,
                       input logic le, input logic [5:0] li, input logic [31:0] ld);
      logic        running, acc, err;
      logic [31:0] word;
      int          edge_no;
      req_valid = v; req_addr = a; flush = fl;
      ld_en = le; ld_addr = li; ld_data = ld;
      running = (edges >= DEPTH);
      acc     = v && running;
      err     = (a % 4 != 0) || (a / 4 >= DEPTH);
      word    = NOP;
      if (!err) word = mem_m[a[7:2]];
      edge_no = edges + 1;
      for (int d = 0; d < NDUT; d++) begin
         int s;
         if (fl) for (int k = 0; k < SLOTS; k++) exp_v[d][k] = 1'b0;
         if (acc) begin
            s = (edge_no + lat_of(d) - 1) % SLOTS;
            exp_v[d][s] = 1'b1;
            exp_d[d][s] = word;
            exp_a[d][s] = a;
            exp_e[d][s] = err;
         end
      end
      if (running && le) mem_m[li] = ld;
      @(posedge clk);
      edges++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic fetch(input logic [31:0] a);
      step(1'b1, a, 1'b0, 1'b0, 6'd0, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
   endtask

   logic [31:0] prog [8] = '{32'h00A00093, 32'h01400113, 32'h002081B3, 32'h40110233,
                             32'h00302023, 32'h00002283, 32'h00000013, 32'h00528313};

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish within 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check("reset rsp_valid", 32'(o_valid[d]), 32'h0);
         check("reset rsp_data",  o_data[d], NOP);
         check("reset rsp_addr",  o_addr[d], 32'h0);
         check("reset rsp_err",   32'(o_err[d]), 32'h0);
         check("reset req_ready", 32'(o_ready[d]), 32'h0);
         check("reset init_busy", 32'(o_busy[d]), 32'h1);
      end
      rst = 1'b0;

      // Fill: requests and loader writes must be ignored for exactly DEPTH cycles
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 32'($urandom_range(63)) << 2, 1'($urandom_range(1)),
              1'b1, 6'($urandom_range(63)), $urandom);

      // Top word after fill
      fetch(32'h0FC);
      idle(4);

      // Load program, then stream it back
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 6'(i), prog[i]);
      for (int i = 0; i < 8; i++) fetch(32'(i * 4));
      idle(5);

      // Same-cycle write and read of index 2, then re-read
      step(1'b1, 32'h08, 1'b0, 1'b1, 6'd2, 32'hDEADBEEF);
      fetch(32'h08);
      idle(5);

      // Misaligned and out-of-range
      fetch(32'h102);
      fetch(32'h100);
      fetch(32'hFFFF_FFFC);
      idle(5);

      // Flush with three in flight plus a redirect on the flush edge
      fetch(32'h00);
      fetch(32'h04);
      fetch(32'h08);
      step(1'b1, 32'h20, 1'b1, 1'b0, 6'd0, 32'h0);
      idle(5);
      // Flush on an empty pipeline
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         int          r;
         r = $urandom_range(9);
         if (r < 7)       a = 32'($urandom_range(63)) << 2;
         else if (r == 7) a = $urandom;
         else if (r == 8) a = 32'(DEPTH * 4 + $urandom_range(7));
         else             a = (32'($urandom_range(63)) << 2) | 32'($urandom_range(1, 3));
         step(1'($urandom_range(9) < 7), a, 1'($urandom_range(9) == 0),
              1'($urandom_range(4) == 0), 6'($urandom_range(63)), $urandom);
      end
      idle(5);

      // Asynchronous reset pulse with responses in flight
      step(1'b0, 32'h0, 1'b0, 1'b1, 6'd0, 32'hCAFE_0001);
      fetch(32'h00);
      fetch(32'h04);
      #2 rst = 1'b1;
      #0.5;
      for (int d = 0; d < NDUT; d++) begin
         check("async rst rsp_valid", 32'(o_valid[d]), 32'h0);
         check("async rst init_busy", 32'(o_busy[d]), 32'h1);
      end
      #0.5 rst = 1'b0;
      model_reset();
      idle(DEPTH);
      fetch(32'h00);
      fetch(32'h04);
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_imem_pipe.md
Name: rv_imem_pipe

Overview:
Parametrised instruction memory for the rv_cpu fetch path. It replaces the single-depth, zero-latency combinational IMEM with the following features:
- a configurable, fully pipelined read latency;
- a synchronous loader port, so benches and boot logic no longer load memory by hierarchical reference;
- a post-reset NOP-fill state machine;
- a flush input that kills in-flight fetches on redirect.

It sits between the IF stage (pc_Q100H request side) and the instruction register feeding decode.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, 4..4096.
LATENCY, 1, cycles from request accept to response valid; 1..4.
NOP_WORD, 32'h00000013, fill value and error-response data.
IDX_W, $clog2(DEPTH), word-index width (derived; not overridden).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request
req_addr  in  32  byte address
req_ready  out  1  request accepted this cycle when req_valid & req_ready
flush  in  1  kill all in-flight responses
rsp_valid  out  1  response valid
rsp_data  out  32  instruction word
rsp_addr  out  32  byte address of the response
rsp_err  out  1  misaligned or out-of-range request
ld_en  in  1  loader write strobe
ld_addr  in  IDX_W  loader word index
ld_data  in  32  loader write data
init_busy  out  1  NOP-fill in progress

Behaviour:
- Reset (async, rst=1):
  - FSM enters FILL and the fill counter goes to 0.
  - All pipeline valid bits clear.
  - rsp_valid=0, rsp_data=NOP_WORD, rsp_addr=0, rsp_err=0, req_ready=0, init_busy=1.
  - Array contents are not reset.
- FSM states:
  - FILL: each cycle write NOP_WORD to word[fill_cnt] and increment fill_cnt. After writing word DEPTH-1, go to RUN on the next edge. FILL lasts exactly DEPTH cycles after rst deasserts.
  - RUN: init_busy=0, req_ready=1. RUN persists until reset.
- Loader:
  - ld_en is honoured in RUN only and ignored in FILL.
  - The write takes effect at the clock edge.
  - A read accepted in the same cycle as a write to the same index returns the old contents; the next accepted read returns the new value.
- Read pipeline:
  - Accepts one request per cycle with no backpressure. rsp is not stalled; the consumer must absorb one response per cycle.
  - At accept, the array is read at req_addr[IDX_W+1:2]. Address, data and error are captured into stage 1, then shift one stage per cycle.
  - rsp_* are the stage-LATENCY outputs: a request accepted at edge N has rsp_valid=1 during cycle N+LATENCY.
  - The pipeline carries addr, data and err per stage. Stage data stays valid-gated: rsp_data=NOP_WORD whenever rsp_valid=0.
- Errors:
  - rsp_err=1 when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH. No wrap-around.
  - An errored response has rsp_data=NOP_WORD and rsp_valid=1.
- Flush:
  - On an edge with flush=1, all stage valid bits clear.
  - A request accepted in that same cycle is NOT dropped; it enters stage 1 valid (it is the redirected fetch).
  - flush with an empty pipeline has no effect.
- Reset mid-operation: everything in flight is lost and the FSM restarts FILL. Prior loader writes survive in the array but are overwritten by the fill.
- req_valid during FILL: req_ready=0, nothing enters the pipeline, and no response is produced.

Test Plan:
1. Reset release with DEPTH=64, LATENCY=1: init_busy=1 for exactly 64 cycles, then req_ready=1. Fetch addr 0x0FC returns 0x00000013, rsp_err=0.
2. Load words 0..7 with 0x00A00093, 0x01400113, 0x002081B3, 0x40110233, 0x00302023, 0x00002283, 0x00000013, 0x00528313. Fetch addrs 0x00..0x1C back-to-back with LATENCY=3: rsp_valid is continuous from 3 cycles after the first accept, data and rsp_addr in order, no gaps.
3. Same-cycle ld_en to idx 2 (data 0xDEADBEEF) and fetch 0x08: the response is 0x002081B3. The next fetch of 0x08 returns 0xDEADBEEF.
4. Fetch 0x102 (misaligned), then 0x100 (out of range for DEPTH=64): both responses have rsp_valid=1, rsp_err=1, rsp_data=0x00000013.
5. LATENCY=4 with requests 0x00, 0x04, 0x08 in flight, then flush together with a request for 0x20: the three old responses never appear. The only response is addr 0x20, 4 cycles after the flush edge.
6. Assert rst for 1 ns mid-stream with 2 responses in flight: rsp_valid drops immediately (async) and init_busy=1. The fill repeats for 64 cycles, and word 0 reads back 0x00000013 afterwards.
